// File: rtl/fetch_align_if.sv
// I-cache read port of the fetch stage: word-address request and same-cycle read data.
interface fetch_align_if;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;

    modport master (output ICACHE_ren, output ICACHE_addr, input ICACHE_rdata);
    modport slave  (input ICACHE_ren, input ICACHE_addr, output ICACHE_rdata);
endinterface

// File: rtl/fetch_align.sv
// PC register and halfword realignment stage feeding the IF/ID register.
// Define FETCH_RVC_EN for 16/32-bit compressed fetch; otherwise every fetch is a 32-bit word.
module fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 memory_stall,
    fetch_align_if.master        icache,
    input  logic [31:0]          branchPC,
    input  logic                 taken,
    input  logic                 flush,
    output logic [31:0]          instructionPC_1,
    output logic                 L_W,
    output logic [31:0]          IF_inst,
    output logic [31:0]          IF_pc,
    output logic                 IF_L_W,
    output logic                 IF_valid
);

    logic [31:0] inst;
    logic        issue;

`ifdef FETCH_RVC_EN

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        HALF   = 2'd1,
        REFILL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:1] pc_q;
    logic [15:0] buf_q, buf_d;
    logic [29:0] word_addr;
    logic        lw;
    logic        ren;
    logic [29:0] addr;
    logic        if_lw_q;
    logic        unused_bits;

    assign word_addr       = pc_q[31:2];
    assign instructionPC_1 = {pc_q, 1'b0};
    assign unused_bits     = branchPC[0];

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
        ren     = 1'b1;
        addr    = word_addr;
        inst    = icache.ICACHE_rdata;
        lw      = 1'b1;
        issue   = 1'b1;
        buf_d   = buf_q;
        state_d = state_q;
        unique case (state_q)
            ALIGN: begin
                if (icache.ICACHE_rdata[1:0] != 2'b11) begin
                    inst    = {16'h0000, icache.ICACHE_rdata[15:0]};
                    lw      = 1'b0;
                    buf_d   = icache.ICACHE_rdata[31:16];
                    state_d = HALF;
                end
            end
            HALF: begin
                if (buf_q[1:0] != 2'b11) begin
                    ren     = 1'b0;
                    inst    = {16'h0000, buf_q};
                    lw      = 1'b0;
                    state_d = ALIGN;
                end else begin
                    // Straddling instruction: low half buffered, high half from the next word.
                    addr  = word_addr + 30'd1;
                    inst  = {icache.ICACHE_rdata[15:0], buf_q};
                    buf_d = icache.ICACHE_rdata[31:16];
                end
            end
            REFILL: begin
                issue   = 1'b0;
                buf_d   = icache.ICACHE_rdata[31:16];
                state_d = HALF;
            end
            default: begin
                issue   = 1'b0;
                state_d = ALIGN;
            end
        endcase
        // A redirect empties the buffer; a halfword target needs one refill cycle.
        if (flush || (issue && taken)) begin
            state_d = branchPC[1] ? REFILL : ALIGN;
        end
    end

    assign icache.ICACHE_ren  = ren;
    assign icache.ICACHE_addr = addr;
    assign L_W                = lw;
    assign IF_L_W             = if_lw_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pc_q     <= RESET_PC[31:1];
            state_q  <= RESET_PC[1] ? REFILL : ALIGN;
            buf_q    <= 16'h0000;
            IF_inst  <= NOP_INST;
            IF_pc    <= 32'h0000_0000;
            if_lw_q  <= 1'b1;
            IF_valid <= 1'b0;
        end else if (!memory_stall) begin
            if (issue || flush) begin
                pc_q <= branchPC[31:1];
            end
            state_q  <= state_d;
            buf_q    <= buf_d;
            IF_valid <= issue && !flush;
            IF_inst  <= (issue && !flush) ? inst : NOP_INST;
            IF_pc    <= {pc_q, 1'b0};
            if_lw_q  <= lw;
        end
    end

`else

    logic [31:2] pc_q;
    logic        unused_bits;

    assign instructionPC_1    = {pc_q, 2'b00};
    assign icache.ICACHE_ren  = 1'b1;
    assign icache.ICACHE_addr = pc_q;
    assign inst               = icache.ICACHE_rdata;
    assign issue              = 1'b1;
    assign L_W                = 1'b1;
    assign IF_L_W             = 1'b1;
    // Without compressed support the target is always taken from branchPC, predicted or not.
    assign unused_bits        = ^{taken, branchPC[1:0]};

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            pc_q     <= RESET_PC[31:2];
            IF_inst  <= NOP_INST;
            IF_pc    <= 32'h0000_0000;
            IF_valid <= 1'b0;
        end else if (!memory_stall) begin
            pc_q     <= branchPC[31:2];
            IF_valid <= issue && !flush;
            IF_inst  <= (issue && !flush) ? inst : NOP_INST;
            IF_pc    <= {pc_q, 2'b00};
        end
    end

`endif

endmodule
